load_store_unit: RTL and testbench

- Memory-stage data-access engine of the 3-stage pipeline, directly upstream of the writeback stage.
- Takes load/store requests from execute and runs a req/ack transaction on the data bus (DMEM or UART registers).
- Aligns and extends load data, and produces the registered rdata that writeback selects.
- Stalls the pipeline while a transaction is outstanding; detects misalignment and bus timeout.

---
 rtl/load_store_unit.sv | 140 ++++++++++++++
 tb/tb_load_store_unit.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Memory-stage load/store engine: issues one req/ack bus transaction per access,
// stalls the pipeline while it is outstanding, and returns formatted load data.
module load_store_unit #(
    parameter int BUS_WIDTH = 32,
    parameter int TIMEOUT   = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ld_en,
    input  logic                 st_en,
    input  logic [2:0]           funct3,
    input  logic [BUS_WIDTH-1:0] addr,
    input  logic [BUS_WIDTH-1:0] wdata_in,
    output logic                 bus_req,
    output logic                 bus_we,
    output logic [BUS_WIDTH-1:0] bus_addr,
    output logic [3:0]           bus_be,
    output logic [BUS_WIDTH-1:0] bus_wdata,
    input  logic [BUS_WIDTH-1:0] bus_rdata,
    input  logic                 bus_ack,
    output logic [BUS_WIDTH-1:0] rdata,
    output logic                 stall,
    output logic                 misalign_exc,
    output logic                 bus_err
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t         state, state_nxt;
    logic [15:0]    timer;
    logic [2:0]     f3_q;
    logic [1:0]     lane_q;

    logic           is_ld, is_st, legal, misaligned, accept, misalign_fire, timeout_hit;
    logic [3:0]           be_fmt;
    logic [BUS_WIDTH-1:0] wdata_fmt;
    logic [BUS_WIDTH-1:0] load_fmt;
    logic [7:0]           byte_v;
    logic [15:0]          half_v;

    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        is_ld = ld_en;
        is_st = st_en & ~ld_en;   // a simultaneous store is dropped
        legal = 1'b0;
        if (is_ld)
            legal = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        else if (is_st)
            legal = funct3 inside {3'b000, 3'b001, 3'b010};
        misaligned    = (funct3[1:0] == 2'b01 && addr[0]) ||
                        (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00);
        accept        = (state == IDLE) && legal && !misaligned;
        misalign_fire = (state == IDLE) && legal && misaligned;
        timeout_hit   = (timer == 16'(TIMEOUT - 1)) && !bus_ack;
    end

    always_comb begin
        be_fmt    = 4'b1111;
        wdata_fmt = wdata_in;
        if (is_st) begin
            case (funct3[1:0])
                2'b00: begin
                    be_fmt    = 4'b0001 << addr[1:0];
                    wdata_fmt = {4{wdata_in[7:0]}};
                end
                2'b01: begin
                    be_fmt    = 4'b0011 << {addr[1], 1'b0};
                    wdata_fmt = {2{wdata_in[15:0]}};
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        byte_v   = 8'(bus_rdata >> {lane_q, 3'b000});
        half_v   = 16'(bus_rdata >> {lane_q[1], 4'b0000});
        load_fmt = bus_rdata;
        case (f3_q)
            3'b000:  load_fmt = {{24{byte_v[7]}}, byte_v};
            3'b100:  load_fmt = {24'b0, byte_v};
            3'b001:  load_fmt = {{16{half_v[15]}}, half_v};
            3'b101:  load_fmt = {16'b0, half_v};
            default: load_fmt = bus_rdata;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = BUSY;
            BUSY:    if (bus_ack || timeout_hit) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Derived from state so an async reset drops the request immediately.
    assign bus_req = (state == BUSY);
    assign stall   = accept || (state == BUSY);

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            timer        <= '0;
            f3_q         <= '0;
            lane_q       <= '0;
            bus_we       <= 1'b0;
            bus_addr     <= '0;
            bus_be       <= '0;
            bus_wdata    <= '0;
            rdata        <= '0;
            misalign_exc <= 1'b0;
            bus_err      <= 1'b0;
        end else begin
            state        <= state_nxt;
            misalign_exc <= misalign_fire;
            bus_err      <= (state == BUSY) && timeout_hit;
            if (accept) begin
                timer     <= '0;
                f3_q      <= funct3;
                lane_q    <= addr[1:0];
                bus_we    <= is_st;
                bus_addr  <= {addr[BUS_WIDTH-1:2], 2'b00};
                bus_be    <= be_fmt;
                bus_wdata <= wdata_fmt;
            end else if (state == BUSY) begin
                timer <= timer + 16'd1;
                if (!bus_we) begin
                    if (bus_ack)
                        rdata <= load_fmt;
                    else if (timeout_hit)
                        rdata <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: loads, stores, misalignment, timeout, reset.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ld_en, st_en;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata_in;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_be;
    logic        bus_ack;
    logic [31:0] rdata;
    logic        stall, misalign_exc, bus_err;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_rdata = 32'h0;

    load_store_unit #(.BUS_WIDTH(32), .TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n), .ld_en(ld_en), .st_en(st_en), .funct3(funct3),
        .addr(addr), .wdata_in(wdata_in), .bus_req(bus_req), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .bus_ack(bus_ack), .rdata(rdata), .stall(stall),
        .misalign_exc(misalign_exc), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ld_en = 0; st_en = 0; funct3 = 0; addr = 0; wdata_in = 0;
        bus_rdata = 0; bus_ack = 0;
        tick(); tick();
        checks++;
        if ({bus_req, bus_we, bus_addr, bus_be, bus_wdata, rdata, stall, misalign_exc, bus_err} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: req=%0b we=%0b addr=%h be=%b wdata=%h rdata=%h stall=%0b mis=%0b err=%0b, required all zero",
                     bus_req, bus_we, bus_addr, bus_be, bus_wdata, rdata, stall, misalign_exc, bus_err);
        end
        rst_n = 1'b1;
        tick();
    endtask

    // Load with ack on the first BUSY cycle; ld_en held through DONE.
    task automatic run_load(input string name, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] word, input logic [31:0] exp);
        ld_en = 1; st_en = 0; funct3 = f3; addr = a;
        #1;
        checks++;
        if (stall !== 1'b1) begin
            failures++; $display("FAIL %s request_stall: got %0b required 1", name, stall);
        end
        tick();
        checks++;
        if (bus_req !== 1'b1 || bus_we !== 1'b0 || bus_addr !== {a[31:2], 2'b00} ||
            bus_be !== 4'b1111 || stall !== 1'b1) begin
            failures++;
            $display("FAIL %s busy_bus: req=%0b we=%0b addr=%h be=%b stall=%0b required 1 0 %h 1111 1",
                     name, bus_req, bus_we, bus_addr, bus_be, stall, {a[31:2], 2'b00});
        end
        bus_rdata = word; bus_ack = 1;
        tick();
        bus_ack = 0; bus_rdata = 0;
        exp_rdata = exp;
        checks++;
        if (rdata !== exp || stall !== 1'b0 || bus_req !== 1'b0) begin
            failures++;
            $display("FAIL %s done: rdata=%h stall=%0b req=%0b required %h 0 0",
                     name, rdata, stall, bus_req, exp);
        end
        tick();
        ld_en = 0;
        checks++;
        if (bus_req !== 1'b0) begin
            failures++; $display("FAIL %s done_ignores_req: bus_req=%0b required 0", name, bus_req);
        end
    endtask

    task automatic test_loads();
        run_load("lw",  3'b010, 32'h104, 32'hDEADBEEF, 32'hDEADBEEF);
        run_load("lb",  3'b000, 32'h203, 32'h80123456, 32'hFFFFFF80);
        run_load("lbu", 3'b100, 32'h203, 32'h80123456, 32'h00000080);
        run_load("lhu", 3'b101, 32'h202, 32'h80123456, 32'h00008012);
        run_load("lh",  3'b001, 32'h202, 32'h80123456, 32'hFFFF8012);
        run_load("lb0", 3'b000, 32'h200, 32'h80123456, 32'h00000056);
    endtask

    task automatic run_store(input string name, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] wd, input logic [3:0] exp_be,
                             input logic [31:0] exp_wd);
        st_en = 1; ld_en = 0; funct3 = f3; addr = a; wdata_in = wd;
        tick();
        st_en = 0;
        checks++;
        if (bus_req !== 1'b1 || bus_we !== 1'b1 || bus_addr !== {a[31:2], 2'b00} ||
            bus_be !== exp_be || bus_wdata !== exp_wd) begin
            failures++;
            $display("FAIL %s busy_bus: req=%0b we=%0b addr=%h be=%b wdata=%h required 1 1 %h %b %h",
                     name, bus_req, bus_we, bus_addr, bus_be, bus_wdata, {a[31:2], 2'b00}, exp_be, exp_wd);
        end
        bus_ack = 1; bus_rdata = 32'h5555AAAA;
        tick();
        bus_ack = 0; bus_rdata = 0;
        checks++;
        if (rdata !== exp_rdata || stall !== 1'b0) begin
            failures++;
            $display("FAIL %s rdata_kept: rdata=%h stall=%0b required %h 0", name, rdata, stall, exp_rdata);
        end
        tick();
    endtask

    task automatic test_stores();
        run_store("sb", 3'b000, 32'h11, 32'h000000A5, 4'b0010, 32'hA5A5A5A5);
        run_store("sh", 3'b001, 32'h12, 32'h1234BEEF, 4'b1100, 32'hBEEFBEEF);
        run_store("sw", 3'b010, 32'h18, 32'hCAFEF00D, 4'b1111, 32'hCAFEF00D);
    endtask

    task automatic run_no_access(input string name, input logic ld, input logic [2:0] f3,
                                 input logic [31:0] a, input logic exp_mis);
        ld_en = ld; st_en = ~ld; funct3 = f3; addr = a;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            failures++; $display("FAIL %s stall: got %0b required 0", name, stall);
        end
        tick();
        ld_en = 0; st_en = 0;
        checks++;
        if (misalign_exc !== exp_mis || bus_req !== 1'b0 || stall !== 1'b0) begin
            failures++;
            $display("FAIL %s pulse: mis=%0b req=%0b stall=%0b required %0b 0 0",
                     name, misalign_exc, bus_req, stall, exp_mis);
        end
        tick();
        checks++;
        if (misalign_exc !== 1'b0 || bus_req !== 1'b0) begin
            failures++;
            $display("FAIL %s after: mis=%0b req=%0b required 0 0", name, misalign_exc, bus_req);
        end
    endtask

    task automatic test_misalign_illegal();
        run_no_access("lh_mis",  1'b1, 3'b001, 32'h3, 1'b1);
        run_no_access("sw_mis",  1'b0, 3'b010, 32'h6, 1'b1);
        run_no_access("ld_ill",  1'b1, 3'b011, 32'h0, 1'b0);
        run_no_access("st_ill",  1'b0, 3'b100, 32'h0, 1'b0);
        // ack outside BUSY must not start anything
        bus_ack = 1; tick(); bus_ack = 0;
        checks++;
        if (bus_req !== 1'b0 || stall !== 1'b0 || rdata !== exp_rdata) begin
            failures++;
            $display("FAIL stray_ack: req=%0b stall=%0b rdata=%h required 0 0 %h",
                     bus_req, stall, rdata, exp_rdata);
        end
    endtask

    task automatic test_load_wins();
        ld_en = 1; st_en = 1; funct3 = 3'b010; addr = 32'h20; wdata_in = 32'h12345678;
        tick();
        ld_en = 0; st_en = 0;
        checks++;
        if (bus_req !== 1'b1 || bus_we !== 1'b0 || bus_be !== 4'b1111) begin
            failures++;
            $display("FAIL load_wins: req=%0b we=%0b be=%b required 1 0 1111", bus_req, bus_we, bus_be);
        end
        bus_ack = 1; bus_rdata = 32'h0BADF00D;
        tick();
        bus_ack = 0; bus_rdata = 0;
        exp_rdata = 32'h0BADF00D;
        checks++;
        if (rdata !== exp_rdata) begin
            failures++; $display("FAIL load_wins_rdata: got %h required %h", rdata, exp_rdata);
        end
        tick();
    endtask

    task automatic test_timeout();
        int req_cycles;
        ld_en = 1; funct3 = 3'b010; addr = 32'h40;
        tick();
        req_cycles = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus_req !== 1'b1) break;
            req_cycles++;
            tick();
        end
        ld_en = 0;
        exp_rdata = 32'h0;
        checks++;
        if (req_cycles != 4 || bus_err !== 1'b1 || rdata !== 32'h0 || stall !== 1'b0) begin
            failures++;
            $display("FAIL timeout: req_cycles=%0d err=%0b rdata=%h stall=%0b required 4 1 00000000 0",
                     req_cycles, bus_err, rdata, stall);
        end
        tick();
        checks++;
        if (bus_err !== 1'b0) begin
            failures++; $display("FAIL timeout_pulse_width: bus_err=%0b required 0", bus_err);
        end
        // ack on the last allowed cycle beats the timeout
        ld_en = 1; funct3 = 3'b010; addr = 32'h44;
        tick();
        ld_en = 0;
        tick(); tick(); tick();
        bus_ack = 1; bus_rdata = 32'h11223344;
        tick();
        bus_ack = 0; bus_rdata = 0;
        exp_rdata = 32'h11223344;
        checks++;
        if (bus_err !== 1'b0 || rdata !== exp_rdata || stall !== 1'b0) begin
            failures++;
            $display("FAIL late_ack: err=%0b rdata=%h stall=%0b required 0 %h 0",
                     bus_err, rdata, stall, exp_rdata);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        ld_en = 1; funct3 = 3'b010; addr = 32'h80;
        tick();
        ld_en = 0;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus_req !== 1'b0 || stall !== 1'b0 || rdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_mid: req=%0b stall=%0b rdata=%h required 0 0 00000000",
                     bus_req, stall, rdata);
        end
        exp_rdata = 32'h0;
        tick();
        rst_n = 1'b1;
        tick();
        run_load("lw_after_reset", 3'b010, 32'h108, 32'hA5A51234, 32'hA5A51234);
    endtask

    initial begin
        test_reset();
        test_loads();
        test_stores();
        test_misalign_illegal();
        test_load_wins();
        test_timeout();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
